// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one decryption round per clock, round keys rolled
// backwards on the fly from round key 10 (optionally derived first from the cipher key).
module aes128_inv_cipher_iter #(
  parameter int unsigned FWD_KEY = 0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_in_block,
  input  logic [127:0] i_in_key,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_out_block
);

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

  state_t       r_state;
  state_t       w_nextState;
  logic [127:0] r_st;
  logic [127:0] r_rk;
  logic [127:0] r_outBlock;
  logic [3:0]   r_round;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254; the chain maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gInv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
    return gmul(r, r);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gInv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] a);
    return gInv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte i sits at [8*(15-i)+:8] with row i%4, column i/4; row k rotates right by k.
  function automatic logic [127:0] invShiftRows(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      src = (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4);
      o[8*(15-i) +: 8] = s[8*(15-src) +: 8];
    end
    return o;
  endfunction

  function automatic logic [127:0] invMixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(15-4*c) +: 8];
      a1 = s[8*(14-4*c) +: 8];
      a2 = s[8*(13-4*c) +: 8];
      a3 = s[8*(12-4*c) +: 8];
      o[8*(15-4*c) +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[8*(14-4*c) +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[8*(13-4*c) +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[8*(12-4*c) +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_p1, w_p2, w_p3;
  logic [31:0]  w_subIn, w_sub, w_n0;
  logic [7:0]   w_rcon;
  logic [127:0] w_fwdKey, w_prk, w_invSr, w_invSub, w_t, w_mix;

  assign {w_w0, w_w1, w_w2, w_w3} = r_rk;
  assign w_rcon = rcon(r_round);
  assign w_p3   = w_w3 ^ w_w2;
  assign w_p2   = w_w2 ^ w_w1;
  assign w_p1   = w_w1 ^ w_w0;

  // One SubWord is shared: forward expansion feeds it w3, the inverse schedule feeds it p3.
  assign w_subIn  = (r_state == KEXP) ? {w_w3[23:0], w_w3[31:24]} : {w_p3[23:0], w_p3[31:24]};
  assign w_sub    = subWord(w_subIn);
  assign w_n0     = w_w0 ^ w_sub ^ {w_rcon, 24'h0};
  assign w_fwdKey = {w_n0, w_w1 ^ w_n0, w_w2 ^ w_w1 ^ w_n0, w_w3 ^ w_w2 ^ w_w1 ^ w_n0};
  assign w_prk    = {w_n0, w_p1, w_p2, w_p3};

  assign w_invSr = invShiftRows(r_st);

  always_comb begin
    w_invSub = '0;
    for (int i = 0; i < 16; i++) w_invSub[8*i +: 8] = invSbox(w_invSr[8*i +: 8]);
  end

  assign w_t   = w_invSub ^ w_prk;
  assign w_mix = invMixColumns(w_t);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_in_valid) w_nextState = (FWD_KEY != 0) ? KEXP : ROUND;
      KEXP:    if (r_round == 4'd10) w_nextState = ROUND;
      ROUND:   if (r_round == 4'd1) w_nextState = DONE;
      DONE:    if (i_out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st       <= '0;
      r_rk       <= '0;
      r_outBlock <= '0;
      r_round    <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_in_valid) begin
          r_rk <= i_in_key;
          if (FWD_KEY != 0) begin
            r_st    <= i_in_block;
            r_round <= 4'd1;
          end else begin
            r_st    <= i_in_block ^ i_in_key;
            r_round <= 4'd10;
          end
        end
        KEXP: begin
          r_rk <= w_fwdKey;
          if (r_round == 4'd10) r_st <= r_st ^ w_fwdKey;
          else                  r_round <= r_round + 4'd1;
        end
        ROUND: begin
          r_rk    <= w_prk;
          r_round <= r_round - 4'd1;
          if (r_round == 4'd1) begin
            r_st       <= w_t;
            r_outBlock <= w_t;
          end else begin
            r_st <= w_mix;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_in_ready  = (r_state == IDLE) & i_rst_n;
    o_out_valid = (r_state == DONE);
    o_out_block = r_outBlock;
  end

endmodule

// File: tb/tb_aes128_inv_cipher_iter.sv
// Self-checking bench: both key modes against a forward AES-128 encryption model, so every
// random plaintext must come back out of the decryptor unchanged.
module tb_aes128_inv_cipher_iter;

  localparam logic [127:0] T1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] T1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] T1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] T1_RK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] T2_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] T2_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] T2_RK  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk;
  logic         rst_n;
  logic         inValid[2];
  logic         inReady[2];
  logic [127:0] inBlock[2];
  logic [127:0] inKey[2];
  logic         outValid[2];
  logic         outReady[2];
  logic [127:0] outBlock[2];

  int compareCount;
  int errorCount;

  logic [7:0]   sboxT[256];
  logic [127:0] refRk[11];

  aes128_inv_cipher_iter #(.FWD_KEY(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(inValid[0]), .o_in_ready(inReady[0]),
    .i_in_block(inBlock[0]), .i_in_key(inKey[0]),
    .o_out_valid(outValid[0]), .i_out_ready(outReady[0]), .o_out_block(outBlock[0])
  );

  aes128_inv_cipher_iter #(.FWD_KEY(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(inValid[1]), .o_in_ready(inReady[1]),
    .i_in_block(inBlock[1]), .i_in_key(inKey[1]),
    .o_out_valid(outValid[1]), .i_out_ready(outReady[1]), .o_out_block(outBlock[1])
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    compareCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [7:0] gf2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from walking the multiplicative group with generator 3 and its inverse.
  task automatic buildSbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sboxT[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sboxT[0] = 8'h63;
  endtask

  task automatic computeRoundKeys(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sboxT[t[23:16]], sboxT[t[15:8]], sboxT[t[7:0]], sboxT[t[31:24]]} ^ {rc, 24'h0};
        rc = gf2(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) refRk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encryptRef(input logic [127:0] pt);
    logic [7:0] s[16];
    logic [7:0] u[16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[8*(15-i) +: 8] ^ refRk[0][8*(15-i) +: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sboxT[s[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) u[r+4*c] = s[r+4*((c+r)%4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
          u[4*c]   = gf2(a0) ^ gf2(a1) ^ a1 ^ a2 ^ a3;
          u[4*c+1] = a0 ^ gf2(a1) ^ gf2(a2) ^ a2 ^ a3;
          u[4*c+2] = a0 ^ a1 ^ gf2(a2) ^ gf2(a3) ^ a3;
          u[4*c+3] = gf2(a0) ^ a0 ^ a1 ^ a2 ^ gf2(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = u[i] ^ refRk[rnd][8*(15-i) +: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[8*(15-i) +: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic waitAccept(input int d);
    int n;
    n = 0;
    while (!inReady[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("inReadyBeforeAccept", 128'(inReady[d]), 128'd1);
    @(negedge clk);
    inValid[d] = 1'b0;
    inBlock[d] = rand128();
    inKey[d]   = rand128();
  endtask

  task automatic waitOut(input int d, output int lat);
    lat = 0;
    while (!outValid[d] && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("outValidRise", 128'(outValid[d]), 128'd1);
  endtask

  task automatic applyStimulus(input int d, input logic [127:0] blk, input logic [127:0] key,
                               input logic [127:0] expPt, input int expLat,
                               input bit earlyReady, input int hold);
    int lat;
    inBlock[d] = blk;
    inKey[d]   = key;
    inValid[d] = 1'b1;
    waitAccept(d);
    if (earlyReady) outReady[d] = 1'b1;
    waitOut(d, lat);
    checkOutput("latency", 128'(lat), 128'(expLat));
    checkOutput("plaintext", outBlock[d], expPt);
    if (!earlyReady) begin
      repeat (hold) begin
        @(negedge clk);
        checkOutput("heldValid", 128'(outValid[d]), 128'd1);
        checkOutput("heldBlock", outBlock[d], expPt);
      end
      outReady[d] = 1'b1;
    end
    @(negedge clk);
    outReady[d] = 1'b0;
    checkOutput("outValidDrop", 128'(outValid[d]), 128'd0);
    checkOutput("inReadyAfterXfer", 128'(inReady[d]), 128'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] vec[2][3];
    logic [127:0] outs[$];
    int outCyc[$];
    int idx, cnt, lat;
    bit acc;
    logic [127:0] key, pt, ct;

    compareCount = 0;
    errorCount   = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      inValid[d] = 1'b0; inBlock[d] = '0; inKey[d] = '0; outReady[d] = 1'b0;
    end
    buildSbox();

    #12;
    for (int d = 0; d < 2; d++) begin
      checkOutput("rstInReady", 128'(inReady[d]), 128'd0);
      checkOutput("rstOutValid", 128'(outValid[d]), 128'd0);
      checkOutput("rstOutBlock", outBlock[d], 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) checkOutput("postRstInReady", 128'(inReady[d]), 128'd1);
    @(negedge clk);

    $display("[TB] known-answer vectors");
    applyStimulus(0, T1_CT, T1_RK, T1_PT, 10, 1'b0, 0);
    applyStimulus(0, T2_CT, T2_RK, T2_PT, 10, 1'b0, 1);
    applyStimulus(1, T1_CT, T1_KEY, T1_PT, 20, 1'b0, 2);

    $display("[TB] backpressure");
    inBlock[0] = T1_CT; inKey[0] = T1_RK; inValid[0] = 1'b1;
    waitAccept(0);
    waitOut(0, lat);
    inValid[0] = 1'b1;
    inBlock[0] = T2_CT; inKey[0] = T2_RK;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("bpValid", 128'(outValid[0]), 128'd1);
      checkOutput("bpBlock", outBlock[0], T1_PT);
      checkOutput("bpInReady", 128'(inReady[0]), 128'd0);
    end
    inValid[0]  = 1'b0;
    outReady[0] = 1'b1;
    @(negedge clk);
    outReady[0] = 1'b0;
    checkOutput("bpReleaseValid", 128'(outValid[0]), 128'd0);
    checkOutput("bpReleaseInReady", 128'(inReady[0]), 128'd1);

    $display("[TB] reset in the middle of the rounds");
    inBlock[0] = T2_CT; inKey[0] = T2_RK; inValid[0] = 1'b1;
    waitAccept(0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstOutValid", 128'(outValid[0]), 128'd0);
    checkOutput("midRstInReady", 128'(inReady[0]), 128'd0);
    checkOutput("midRstOutBlock", outBlock[0], 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midRstRelease", 128'(inReady[0]), 128'd1);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (outValid[0]) cnt++;
    end
    checkOutput("staleOutput", 128'(cnt), 128'd0);
    applyStimulus(0, T1_CT, T1_RK, T1_PT, 10, 1'b0, 0);

    $display("[TB] back-to-back");
    vec[0] = '{T1_CT, T1_RK, T1_PT};
    vec[1] = '{T2_CT, T2_RK, T2_PT};
    idx = 0;
    inBlock[0] = vec[0][0]; inKey[0] = vec[0][1]; inValid[0] = 1'b1;
    outReady[0] = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (outValid[0]) begin
        outs.push_back(outBlock[0]);
        outCyc.push_back(cyc);
      end
      acc = inValid[0] && inReady[0];
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 2) begin
          inBlock[0] = vec[idx][0]; inKey[0] = vec[idx][1];
        end else begin
          inValid[0] = 1'b0;
        end
      end
    end
    outReady[0] = 1'b0;
    checkOutput("b2bCount", 128'(outs.size()), 128'd2);
    if (outs.size() == 2) begin
      checkOutput("b2bFirst", outs[0], vec[0][2]);
      checkOutput("b2bSecond", outs[1], vec[1][2]);
      checkOutput("b2bInterval", 128'(outCyc[1] - outCyc[0]), 128'd12);
    end

    $display("[TB] random blocks in both key modes");
    for (int n = 0; n < 10; n++) begin
      key = rand128();
      pt  = rand128();
      computeRoundKeys(key);
      ct = encryptRef(pt);
      applyStimulus(0, ct, refRk[10], pt, 10, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      applyStimulus(1, ct, key, pt, 20, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
    $finish;
  end

endmodule
